// File: rtl/dmem_arb_pkg.sv
// Shared types and port indices for the data-memory port arbiter.
package dmem_arb_pkg;
    typedef enum logic {ARB = 1'b0, LOCK1 = 1'b1} arb_state_t;
    localparam int PORT_CPU = 0;
    localparam int PORT_LDR = 1;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of both master ports plus the data-memory side of the arbiter.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_rvalid;
    logic              m1_req;
    logic              m1_we;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_rvalid;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              cpu_stall;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rdata, m0_rvalid,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rdata, m1_rvalid,
        output mem_we, mem_re, mem_addr, mem_wdata,
        input  mem_rdata,
        output cpu_stall
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rdata, m0_rvalid,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  mem_we, mem_re, mem_addr, mem_wdata,
        output mem_rdata,
        input  cpu_stall
    );
endinterface

// File: rtl/dmem_port_arbiter_sat_cnt4.sv
// 4-bit counter that stops at a limit; clear wins over increment.
module sat_cnt4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic [3:0] cnt
);
    logic [3:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_reg <= 4'd0;
        else if (clr)
            cnt_reg <= 4'd0;
        else if (inc && (cnt_reg != limit))
            cnt_reg <= cnt_reg + 4'd1;
    end

    assign cnt = cnt_reg;
endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the data-memory port: CPU has priority, loader is
// protected by a starvation counter and may lock the port for bounded bursts.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic CLK,
    input  logic rst_n,
    dmem_port_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_LIM  = 4'(MAX_WAIT);
    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
    localparam logic [3:0] BURST_END = 4'(BURST_MAX - 1);

    arb_state_t state_reg, state_next;
    logic       slot_reg, slot_next;
    logic [1:0] gnt;
    logic [3:0] wait_cnt, burst_cnt;
    logic       burst_inc, burst_clr, burst_last;
    logic       m0_rd_acc, m1_rd_acc;

    // Grants are combinational and forced low while reset is asserted.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (state_reg == LOCK1)
                gnt[PORT_LDR] = bus.m1_req;
            else if (slot_reg && bus.m0_req)
                gnt[PORT_CPU] = 1'b1;
            else if (bus.m0_req && bus.m1_req) begin
                if (wait_cnt == WAIT_LIM)
                    gnt[PORT_LDR] = 1'b1;
                else
                    gnt[PORT_CPU] = 1'b1;
            end else begin
                gnt[PORT_CPU] = bus.m0_req;
                gnt[PORT_LDR] = bus.m1_req;
            end
        end
    end

    // The beat that brings the burst to BURST_MAX ends it and books a CPU slot.
    assign burst_last = gnt[PORT_LDR] && bus.m1_lock && (burst_cnt == BURST_END);

    always_comb begin
        state_next = state_reg;
        slot_next  = 1'b0;
        burst_inc  = 1'b0;
        burst_clr  = 1'b0;
        case (state_reg)
            ARB: begin
                if (gnt[PORT_LDR] && bus.m1_lock) begin
                    if (burst_last)
                        slot_next = 1'b1;
                    else begin
                        state_next = LOCK1;
                        burst_inc  = 1'b1;
                    end
                end
            end
            LOCK1: begin
                if (!bus.m1_req || !bus.m1_lock || burst_last) begin
                    state_next = ARB;
                    burst_clr  = 1'b1;
                    slot_next  = burst_last;
                end else
                    burst_inc = 1'b1;
            end
            default: state_next = ARB;
        endcase
    end

    sat_cnt4 u_wait_cnt (
        .clk   (CLK),
        .rst_n (rst_n),
        .inc   (bus.m1_req && !gnt[PORT_LDR]),
        .clr   (gnt[PORT_LDR] || !bus.m1_req),
        .limit (WAIT_LIM),
        .cnt   (wait_cnt)
    );

    sat_cnt4 u_burst_cnt (
        .clk   (CLK),
        .rst_n (rst_n),
        .inc   (burst_inc),
        .clr   (burst_clr),
        .limit (BURST_LIM),
        .cnt   (burst_cnt)
    );

    assign m0_rd_acc = gnt[PORT_CPU] && !bus.m0_we;
    assign m1_rd_acc = gnt[PORT_LDR] && !bus.m1_we;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ARB;
            slot_reg      <= 1'b0;
            bus.m0_rdata  <= '0;
            bus.m0_rvalid <= 1'b0;
            bus.m1_rdata  <= '0;
            bus.m1_rvalid <= 1'b0;
        end else begin
            state_reg     <= state_next;
            slot_reg      <= slot_next;
            bus.m0_rvalid <= m0_rd_acc;
            bus.m1_rvalid <= m1_rd_acc;
            if (m0_rd_acc)
                bus.m0_rdata <= bus.mem_rdata;
            if (m1_rd_acc)
                bus.m1_rdata <= bus.mem_rdata;
        end
    end

    assign bus.m0_gnt    = gnt[PORT_CPU];
    assign bus.m1_gnt    = gnt[PORT_LDR];
    assign bus.mem_we    = (gnt[PORT_CPU] && bus.m0_we) || (gnt[PORT_LDR] && bus.m1_we);
    assign bus.mem_re    = m0_rd_acc || m1_rd_acc;
    assign bus.mem_addr  = gnt[PORT_LDR] ? bus.m1_addr  : (gnt[PORT_CPU] ? bus.m0_addr  : '0);
    assign bus.mem_wdata = gnt[PORT_LDR] ? bus.m1_wdata : (gnt[PORT_CPU] ? bus.m0_wdata : '0);
    assign bus.cpu_stall = rst_n && bus.m0_req && !gnt[PORT_CPU];
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbitration rules and a word-addressed memory.
module tb_dmem_port_arbiter;
    localparam int MAX_WAIT  = 4;
    localparam int BURST_MAX = 8;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: denied-cycle count, beats in the current lock burst, booked CPU slot.
    int          waited = 0;
    int          beats  = 0;
    bit          slot   = 1'b0;
    logic [31:0] e_rd0 = '0, e_rd1 = '0;
    logic        e_v0 = 1'b0, e_v1 = 1'b0;
    logic        obs_g0, obs_g1;
    int          step_no = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        waited = 0; beats = 0; slot = 1'b0;
        e_rd0 = '0; e_rd1 = '0; e_v0 = 1'b0; e_v1 = 1'b0;
    endtask

    task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic l1,
                        input logic [31:0] a1, input logic [31:0] d1);
        logic p0, p1;
        logic [31:0] e_addr, e_wdata;
        @(negedge CLK);
        step_no++;
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_lock = l1; bus.m1_addr = a1; bus.m1_wdata = d1;
        if (beats > 0) begin
            p1 = r1; p0 = 1'b0;
        end else if (slot && r0) begin
            p0 = 1'b1; p1 = 1'b0;
        end else if (r0 && r1) begin
            p1 = (waited >= MAX_WAIT); p0 = !p1;
        end else begin
            p0 = r0; p1 = r1;
        end
        e_addr  = p1 ? a1 : (p0 ? a0 : 32'h0);
        e_wdata = p1 ? d1 : (p0 ? d0 : 32'h0);
        #1;
        obs_g0 = bus.m0_gnt;
        obs_g1 = bus.m1_gnt;
        check("m0_gnt", {31'b0, bus.m0_gnt}, {31'b0, p0});
        check("m1_gnt", {31'b0, bus.m1_gnt}, {31'b0, p1});
        check("mem_we", {31'b0, bus.mem_we}, {31'b0, (p0 & w0) | (p1 & w1)});
        check("mem_re", {31'b0, bus.mem_re}, {31'b0, (p0 & ~w0) | (p1 & ~w1)});
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_wdata", bus.mem_wdata, e_wdata);
        check("cpu_stall", {31'b0, bus.cpu_stall}, {31'b0, r0 & ~p0});
        @(posedge CLK);
        e_v0 = p0 & ~w0;
        e_v1 = p1 & ~w1;
        if (e_v0) e_rd0 = mem[a0[9:2]];
        if (e_v1) e_rd1 = mem[a1[9:2]];
        if (p0 && w0) mem[a0[9:2]] = d0;
        if (p1 && w1) mem[a1[9:2]] = d1;
        slot = 1'b0;
        if (!r1) begin
            waited = 0; beats = 0;
        end else if (p1) begin
            waited = 0;
            if (l1) begin
                beats++;
                if (beats == BURST_MAX) begin
                    beats = 0; slot = 1'b1;
                end
            end else
                beats = 0;
        end else if (waited < MAX_WAIT)
            waited++;
        #1;
        check("m0_rvalid", {31'b0, bus.m0_rvalid}, {31'b0, e_v0});
        check("m0_rdata", bus.m0_rdata, e_rd0);
        check("m1_rvalid", {31'b0, bus.m1_rvalid}, {31'b0, e_v1});
        check("m1_rdata", bus.m1_rdata, e_rd1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        int m1_done;
        int budget;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_lock = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;

        // Power-on reset with a pending CPU request: everything stays quiet.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        bus.m0_req = 1'b1;
        #1;
        check("rst_m0_gnt", {31'b0, bus.m0_gnt}, 32'h0);
        check("rst_cpu_stall", {31'b0, bus.cpu_stall}, 32'h0);
        check("rst_mem_re", {31'b0, bus.mem_re}, 32'h0);
        check("rst_m0_rdata", bus.m0_rdata, 32'h0);
        @(negedge CLK);
        rst_n = 1'b1;
        model_reset();

        // Single CPU read returns the stored word the next cycle.
        mem[32'h10 >> 2] = 32'hDEADBEEF;
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t2_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
        idle();

        // Continuous contention: loader wins only the fifth cycle.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'h40 + 32'(i * 4), 32'h0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
            check("t3_m1_turn", {31'b0, obs_g1}, {31'b0, (i == 4)});
        end
        idle();

        // Locked loader burst of 12 writes against a busy CPU.
        m1_done = 0;
        budget  = 0;
        while (m1_done < 12 && budget < 60) begin
            step(budget > 0, 1'b0, 32'h200, 32'h0,
                 1'b1, 1'b1, 1'b1, 32'h100 + 32'(m1_done * 4), 32'h1000 + 32'(m1_done));
            if (budget <= 8)
                check("t4_burst_owner", {31'b0, obs_g1}, {31'b0, (budget < 8)});
            if (obs_g1) m1_done++;
            budget++;
        end
        check("t4_burst_done", 32'(m1_done), 32'd12);
        idle();

        // Loader write then CPU read of the same word.
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h55);
        step(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t5_m0_rdata", bus.m0_rdata, 32'h55);
        idle();

        // Lock burst abandoned after three beats hands the port back to the CPU.
        for (int i = 0; i < 3; i++)
            step(i > 0, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 1'b1, 32'h300 + 32'(i * 4), 32'h0);
        step(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t6_m0_back", {31'b0, obs_g0}, 32'h1);

        // Reset in the middle of a read and a lock burst drops everything.
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
        @(negedge CLK);
        bus.m0_req = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_m1_rvalid", {31'b0, bus.m1_rvalid}, 32'h0);
        check("mid_rst_m1_rdata", bus.m1_rdata, 32'h0);
        check("mid_rst_m1_gnt", {31'b0, bus.m1_gnt}, 32'h0);
        check("mid_rst_mem_addr", bus.mem_addr, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 1'b0, 32'h48, 32'h0);
        check("post_rst_m0_first", {31'b0, obs_g0}, 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 1'(($urandom)), 32'($urandom_range(0, 255)) << 2, $urandom,
                 ($urandom_range(0, 2) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                 32'($urandom_range(0, 255)) << 2, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
